multicycle_ctrl: RTL and testbench

Main control FSM for the multicycle RV32I core. Sequences each instruction through fetch, decode, execute, memory and writeback. Drives the immediate extender's `immsrc` select, ALU operand muxes, result mux, register-file/memory/IR/PC write enables, and the memory address select. Stalls on a memory ready handshake and traps on unsupported opcodes.

---
 rtl/multicycle_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle RV32I core.
// Sequences fetch/decode/execute/memory/writeback and drives datapath selects and write enables.
module multicycle_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       lt,
  input  logic       ltu,
  input  logic       mem_ready,
  output logic [2:0] immsrc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [1:0] resultsrc,
  output logic       adrsrc,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       regwrite,
  output logic       memwrite,
  output logic       instr_done,
  output logic       trap
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JALR     = 4'd10;
  localparam logic [3:0] S_JAL      = 4'd11;
  localparam logic [3:0] S_LUI      = 4'd12;
  localparam logic [3:0] S_AUIPC    = 4'd13;
  localparam logic [3:0] S_ILLEGAL  = 4'd14;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  logic [3:0] state, state_next;
  logic [2:0] dec_immsrc;
  logic       taken;
  logic       unused_funct7b5;

  // funct7b5 belongs to the ALU decoder; it only passes by this block
  assign unused_funct7b5 = funct7b5;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_next;
  end

  // trap rises together with entry into ILLEGAL so it is visible for the whole stay
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      trap <= 1'b0;
    else if (state_next == S_ILLEGAL) trap <= 1'b1;
  end

  always_comb begin
    state_next = S_FETCH;
    case (state)
      S_FETCH:    state_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_R:              state_next = S_EXECR;
          OP_I:              state_next = S_EXECI;
          OP_BRANCH:         state_next = S_BRANCH;
          OP_JAL:            state_next = S_JAL;
          OP_JALR:           state_next = S_JALR;
          OP_LUI:            state_next = S_LUI;
          OP_AUIPC:          state_next = S_AUIPC;
          default:           state_next = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   state_next = opcode[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_next = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_next = S_FETCH;
      S_MEMWRITE: state_next = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECR:    state_next = S_ALUWB;
      S_EXECI:    state_next = S_ALUWB;
      S_ALUWB:    state_next = S_FETCH;
      S_BRANCH:   state_next = S_FETCH;
      S_JALR:     state_next = S_JAL;
      S_JAL:      state_next = S_ALUWB;
      S_LUI:      state_next = S_ALUWB;
      S_AUIPC:    state_next = S_ALUWB;
      S_ILLEGAL:  state_next = S_ILLEGAL;
      default:    state_next = S_FETCH;
    endcase
  end

  always_comb begin
    dec_immsrc = IMM_I;
    case (opcode)
      OP_STORE:         dec_immsrc = IMM_S;
      OP_BRANCH:        dec_immsrc = IMM_B;
      OP_LUI, OP_AUIPC: dec_immsrc = IMM_U;
      OP_JAL:           dec_immsrc = IMM_J;
      default:          dec_immsrc = IMM_I;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = !zero;
      3'b100:  taken = lt;
      3'b101:  taken = !lt;
      3'b110:  taken = ltu;
      3'b111:  taken = !ltu;
      default: taken = 1'b0;
    endcase
  end

  // Moore decode; only FETCH, MEMWRITE and BRANCH also look at live inputs
  always_comb begin
    immsrc     = IMM_I;
    alusrca    = 2'b00;
    alusrcb    = 2'b00;
    aluop      = 2'b00;
    resultsrc  = 2'b00;
    adrsrc     = 1'b0;
    irwrite    = 1'b0;
    pcwrite    = 1'b0;
    regwrite   = 1'b0;
    memwrite   = 1'b0;
    instr_done = 1'b0;
    case (state)
      S_FETCH: begin
        alusrcb   = 2'b10;
        resultsrc = 2'b10;
        irwrite   = mem_ready;
        pcwrite   = mem_ready;
      end
      S_DECODE: begin
        alusrca = 2'b01;
        alusrcb = 2'b01;
        immsrc  = dec_immsrc;
      end
      S_MEMADR: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
        immsrc  = opcode[5] ? IMM_S : IMM_I;
      end
      S_MEMREAD: adrsrc = 1'b1;
      S_MEMWB: begin
        resultsrc  = 2'b01;
        regwrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        adrsrc     = 1'b1;
        memwrite   = 1'b1;
        instr_done = mem_ready;
      end
      S_EXECR: begin
        alusrca = 2'b10;
        aluop   = 2'b10;
      end
      S_EXECI: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
        aluop   = 2'b10;
      end
      S_ALUWB: begin
        regwrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alusrca    = 2'b10;
        aluop      = 2'b01;
        immsrc     = IMM_B;
        pcwrite    = taken;
        instr_done = 1'b1;
      end
      S_JALR: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
      end
      S_JAL: begin
        alusrca = 2'b01;
        alusrcb = 2'b10;
        pcwrite = 1'b1;
        immsrc  = IMM_J;
      end
      S_LUI: begin
        alusrca = 2'b11;
        alusrcb = 2'b01;
        immsrc  = IMM_U;
      end
      S_AUIPC: begin
        alusrca = 2'b01;
        alusrcb = 2'b01;
        immsrc  = IMM_U;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: each instruction is expanded into its phase sequence,
// stalls are injected randomly, and every cycle's outputs are compared with a spec-level model.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5, zero, lt, ltu, mem_ready;
  logic [2:0] immsrc;
  logic [1:0] alusrca, alusrcb, aluop, resultsrc;
  logic       adrsrc, irwrite, pcwrite, regwrite, memwrite, instr_done, trap;

  int tests = 0;
  int fails = 0;
  logic [31:0] ra, rb;
  logic [6:0]  ops [10];

  typedef enum {P_FETCH, P_DECODE, P_MEMADR, P_MEMREAD, P_MEMWB, P_MEMWRITE, P_EXECR, P_EXECI,
                P_ALUWB, P_BRANCH, P_JALR, P_JAL, P_LUI, P_AUIPC, P_ILLEGAL, P_RESET} phase_t;

  typedef struct packed {
    logic [2:0] immsrc;
    logic [1:0] alusrca, alusrcb, aluop, resultsrc;
    logic adrsrc, irwrite, pcwrite, regwrite, memwrite, instr_done, trap;
  } outs_t;

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
    .immsrc(immsrc), .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop),
    .resultsrc(resultsrc), .adrsrc(adrsrc), .irwrite(irwrite), .pcwrite(pcwrite),
    .regwrite(regwrite), .memwrite(memwrite), .instr_done(instr_done), .trap(trap)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] imm_kind(input logic [6:0] op);
    if (op == 7'b0100011) return 3'b001;
    if (op == 7'b1100011) return 3'b010;
    if (op == 7'b0110111 || op == 7'b0010111) return 3'b011;
    if (op == 7'b1101111) return 3'b100;
    return 3'b000;
  endfunction

  // branch outcome from the actual operand values rather than from the flags
  function automatic logic branch_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return $signed(a) < $signed(b);
      3'b101:  return $signed(a) >= $signed(b);
      3'b110:  return a < b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic outs_t model(input phase_t ph, input logic mr);
    outs_t o;
    o = '0;
    case (ph)
      P_FETCH, P_RESET: begin o.alusrcb = 2; o.resultsrc = 2; o.irwrite = mr; o.pcwrite = mr; end
      P_DECODE:   begin o.alusrca = 1; o.alusrcb = 1; o.immsrc = imm_kind(opcode); end
      P_MEMADR:   begin o.alusrca = 2; o.alusrcb = 1; o.immsrc = (opcode == 7'b0100011) ? 3'b001 : 3'b000; end
      P_MEMREAD:  o.adrsrc = 1;
      P_MEMWB:    begin o.resultsrc = 1; o.regwrite = 1; o.instr_done = 1; end
      P_MEMWRITE: begin o.adrsrc = 1; o.memwrite = 1; o.instr_done = mr; end
      P_EXECR:    begin o.alusrca = 2; o.aluop = 2; end
      P_EXECI:    begin o.alusrca = 2; o.alusrcb = 1; o.aluop = 2; end
      P_ALUWB:    begin o.regwrite = 1; o.instr_done = 1; end
      P_BRANCH:   begin o.alusrca = 2; o.aluop = 1; o.immsrc = 2; o.instr_done = 1;
                        o.pcwrite = branch_taken(funct3, ra, rb); end
      P_JALR:     begin o.alusrca = 2; o.alusrcb = 1; end
      P_JAL:      begin o.alusrca = 1; o.alusrcb = 2; o.pcwrite = 1; o.immsrc = 4; end
      P_LUI:      begin o.alusrca = 3; o.alusrcb = 1; o.immsrc = 3; end
      P_AUIPC:    begin o.alusrca = 1; o.alusrcb = 1; o.immsrc = 3; end
      P_ILLEGAL:  o.trap = 1;
      default: ;
    endcase
    return o;
  endfunction

  task automatic checkOutput(input string tag, input outs_t expected);
    outs_t got;
    got = {immsrc, alusrca, alusrcb, aluop, resultsrc,
           adrsrc, irwrite, pcwrite, regwrite, memwrite, instr_done, trap};
    tests++;
    assert (got === expected) else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, got, expected);
    end
  endtask

  task automatic applyStimulus(input logic mr);
    mem_ready = mr;
    zero      = (ra == rb);
    lt        = ($signed(ra) < $signed(rb));
    ltu       = (ra < rb);
    funct7b5  = 1'($urandom_range(0, 1));
  endtask

  // one clock cycle: drive at the falling edge, check 1 ns later, wait for the next falling edge
  task automatic step(input phase_t ph, input logic mr);
    applyStimulus(mr);
    #1;
    checkOutput(ph.name(), model(ph, mr));
    @(negedge clk);
  endtask

  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] b, input int fstall, input int mstall);
    phase_t ph[$];
    opcode = op; funct3 = f3; ra = a; rb = b;
    ph.push_back(P_FETCH);
    ph.push_back(P_DECODE);
    case (op)
      7'b0000011: begin ph.push_back(P_MEMADR); ph.push_back(P_MEMREAD); ph.push_back(P_MEMWB); end
      7'b0100011: begin ph.push_back(P_MEMADR); ph.push_back(P_MEMWRITE); end
      7'b0110011: begin ph.push_back(P_EXECR); ph.push_back(P_ALUWB); end
      7'b0010011: begin ph.push_back(P_EXECI); ph.push_back(P_ALUWB); end
      7'b1100011: ph.push_back(P_BRANCH);
      7'b1101111: begin ph.push_back(P_JAL); ph.push_back(P_ALUWB); end
      7'b1100111: begin ph.push_back(P_JALR); ph.push_back(P_JAL); ph.push_back(P_ALUWB); end
      7'b0110111: begin ph.push_back(P_LUI); ph.push_back(P_ALUWB); end
      7'b0010111: begin ph.push_back(P_AUIPC); ph.push_back(P_ALUWB); end
      default:    ph.push_back(P_ILLEGAL);
    endcase
    foreach (ph[i]) begin
      if (ph[i] == P_FETCH || ph[i] == P_MEMREAD || ph[i] == P_MEMWRITE) begin
        int n;
        n = (ph[i] == P_FETCH) ? fstall : mstall;
        for (int k = 0; k <= n; k++) step(ph[i], k == n);
      end else begin
        step(ph[i], 1'($urandom_range(0, 1)));
      end
    end
  endtask

  initial begin
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1100011};
    rst_n = 1'b1; opcode = 7'b0110011; funct3 = 3'b000; ra = '0; rb = '0;
    applyStimulus(1'b1);
    #2 rst_n = 1'b0;
    #1 checkOutput("reset_mr1", model(P_RESET, 1'b1));
    mem_ready = 1'b0;
    #1 checkOutput("reset_mr0", model(P_RESET, 1'b0));
    @(negedge clk);
    rst_n = 1'b1;

    run_instr(7'b0110011, 3'b000, 32'd3, 32'd4, 0, 0);
    run_instr(7'b0000011, 3'b010, 32'd8, 32'd0, 0, 3);
    run_instr(7'b1100011, 3'b001, 32'd1, 32'd2, 0, 0);
    run_instr(7'b1100011, 3'b001, 32'd5, 32'd5, 1, 0);
    run_instr(7'b1100111, 3'b000, 32'd100, 32'd7, 0, 0);
    run_instr(7'b0100011, 3'b010, 32'd9, 32'd1, 2, 2);
    run_instr(7'b1100011, 3'b000, 32'd7, 32'd7, 0, 0);
    run_instr(7'b1100011, 3'b100, 32'hFFFF_FFFF, 32'd1, 0, 0);
    run_instr(7'b1100011, 3'b111, 32'hFFFF_FFFF, 32'd1, 0, 0);
    run_instr(7'b1100011, 3'b010, 32'd1, 32'd1, 0, 0);
    run_instr(7'b0110111, 3'b000, 32'd0, 32'd0, 0, 0);
    run_instr(7'b0010111, 3'b000, 32'd0, 32'd0, 0, 0);
    run_instr(7'b1101111, 3'b000, 32'd0, 32'd0, 0, 0);
    run_instr(7'b0010011, 3'b000, 32'd0, 32'd0, 0, 0);

    for (int i = 0; i < 60; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      run_instr(ops[$urandom_range(0, 9)], 3'($urandom_range(0, 7)), a, b,
                $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // reset arriving in the middle of a stalled store
    opcode = 7'b0100011; funct3 = 3'b010;
    step(P_FETCH, 1'b1);
    step(P_DECODE, 1'b1);
    step(P_MEMADR, 1'b1);
    applyStimulus(1'b0);
    #1 checkOutput("memwrite_stall", model(P_MEMWRITE, 1'b0));
    #1 rst_n = 1'b0;
    #1 checkOutput("reset_in_memwrite", model(P_RESET, 1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    run_instr(7'b0110011, 3'b000, 32'd1, 32'd1, 1, 0);

    // unsupported opcode: trap must hold with no enables until reset
    opcode = 7'b0000000; funct3 = 3'b000;
    step(P_FETCH, 1'b1);
    step(P_DECODE, 1'b1);
    for (int i = 0; i < 12; i++) step(P_ILLEGAL, 1'($urandom_range(0, 1)));
    rst_n = 1'b0;
    applyStimulus(1'b1);
    #1 checkOutput("reset_from_illegal", model(P_RESET, 1'b1));
    @(negedge clk);
    rst_n = 1'b1;
    run_instr(7'b0110011, 3'b000, 32'd2, 32'd3, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
